// File: rtl/key_state_tracker.sv
// PS/2 set-2 scan-code decoder that maintains a 512-bit held-key vector indexed by {extended, code}.
// Optional build macro: KEY_REPEAT_FILTER_EN suppresses makes of keys that are already held.
module key_state_tracker #(
    parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    input  logic         byte_err,
    output logic [511:0] key_down,
    output logic [8:0]   last_change,
    output logic         key_is_make,
    output logic         key_valid,
    output logic         seq_err
);

    localparam int unsigned    TmoW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

    localparam logic [7:0] CodeExt   = 8'hE0;
    localparam logic [7:0] CodeBrk   = 8'hF0;
    localparam logic [7:0] CodePause = 8'hE1;

    // Bytes following E1 that belong to the Pause make sequence.
    localparam logic [2:0] PauseTail = 3'd7;

    typedef enum logic [2:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk,
        StSkip
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      skip_q, skip_d;
    logic [TmoW-1:0] tmo_q, tmo_d;

    logic [511:0] key_down_q, key_down_d;
    logic [8:0]   last_change_q, last_change_d;
    logic         key_is_make_q, key_is_make_d;
    logic         key_valid_q, key_valid_d;
    logic         seq_err_q, seq_err_d;

    logic is_prefix;
    logic is_overrun;
    logic is_ignored;
    logic tmo_hit;

    always_comb begin
        is_prefix  = (byte_in == CodeExt) || (byte_in == CodeBrk) || (byte_in == CodePause);
        is_overrun = (byte_in == 8'h00) || (byte_in == 8'hFF);
        is_ignored = (byte_in == 8'hAA) || (byte_in == 8'hFA) || (byte_in == 8'hEE) ||
                     (byte_in == 8'hFC) || (byte_in == 8'hFE);
        tmo_hit    = (state_q != StIdle) && (tmo_q == TmoLast);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            skip_q        <= '0;
            tmo_q         <= '0;
            key_down_q    <= '0;
            last_change_q <= '0;
            key_is_make_q <= 1'b0;
            key_valid_q   <= 1'b0;
            seq_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            skip_q        <= skip_d;
            tmo_q         <= tmo_d;
            key_down_q    <= key_down_d;
            last_change_q <= last_change_d;
            key_is_make_q <= key_is_make_d;
            key_valid_q   <= key_valid_d;
            seq_err_q     <= seq_err_d;
        end
    end

    // Next-state: a received byte always takes priority over a pending timeout.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        tmo_d   = tmo_q;
        if (byte_valid) begin
            tmo_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (byte_in == CodeExt) begin
                        state_d = StExt;
                    end else if (byte_in == CodeBrk) begin
                        state_d = StBrk;
                    end else if (byte_in == CodePause) begin
                        state_d = StSkip;
                        skip_d  = PauseTail;
                    end
                end
                StExt: begin
                    if (byte_in == CodeBrk) begin
                        state_d = StExtBrk;
                    end else if (byte_in != CodeExt) begin
                        state_d = StIdle;
                    end
                end
                StBrk, StExtBrk: state_d = StIdle;
                StSkip: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (byte_err || tmo_hit) begin
            state_d = StIdle;
            skip_d  = '0;
            tmo_d   = '0;
        end else if (state_q != StIdle) begin
            tmo_d = tmo_q + TmoW'(1);
        end
    end

    // Output next-values: decode the byte into a make, break, clear or discard.
    always_comb begin
        logic       do_make;
        logic       do_break;
        logic       do_clear;
        logic [8:0] idx;

        do_make  = 1'b0;
        do_break = 1'b0;
        do_clear = 1'b0;
        idx      = {(state_q == StExt) || (state_q == StExtBrk), byte_in};

        key_down_d    = key_down_q;
        last_change_d = last_change_q;
        key_is_make_d = key_is_make_q;
        key_valid_d   = 1'b0;
        seq_err_d     = 1'b0;

        if (byte_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (is_overrun) begin
                        do_clear = 1'b1;
                    end else if (!is_prefix && !is_ignored) begin
                        do_make = 1'b1;
                    end
                end
                StExt: begin
                    if ((byte_in != CodeBrk) && (byte_in != CodeExt)) begin
                        do_make = 1'b1;
                    end
                end
                StBrk, StExtBrk: begin
                    if (is_prefix) begin
                        seq_err_d = 1'b1;
                    end else begin
                        do_break = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (byte_err || tmo_hit) begin
            seq_err_d = 1'b1;
        end

        if (do_clear) begin
            key_down_d = '0;
        end

        if (do_make) begin
`ifdef KEY_REPEAT_FILTER_EN
            if (!key_down_q[idx]) begin
                key_down_d[idx] = 1'b1;
                last_change_d   = idx;
                key_is_make_d   = 1'b1;
                key_valid_d     = 1'b1;
            end
`else
            key_down_d[idx] = 1'b1;
            last_change_d   = idx;
            key_is_make_d   = 1'b1;
            key_valid_d     = 1'b1;
`endif
        end

        if (do_break) begin
            key_down_d[idx] = 1'b0;
            last_change_d   = idx;
            key_is_make_d   = 1'b0;
            key_valid_d     = 1'b1;
        end
    end

    assign key_down    = key_down_q;
    assign last_change = last_change_q;
    assign key_is_make = key_is_make_q;
    assign key_valid   = key_valid_q;
    assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_key_state_tracker.sv
// Bench for key_state_tracker: vector table through a scoreboard queue, plus timeout/reset sequences.
module tb_key_state_tracker;

    localparam int unsigned Tmo = 50;

`ifdef KEY_REPEAT_FILTER_EN
    localparam logic RepFilt = 1'b1;
`else
    localparam logic RepFilt = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_err;
    logic [511:0] key_down;
    logic [8:0]   last_change;
    logic         key_is_make;
    logic         key_valid;
    logic         seq_err;

    key_state_tracker #(
        .TIMEOUT_CYC(Tmo)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_err   (byte_err),
        .key_down   (key_down),
        .last_change(last_change),
        .key_is_make(key_is_make),
        .key_valid  (key_valid),
        .seq_err    (seq_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       v;
        logic       e;
        logic [7:0] b;
        logic       kv;
        logic       se;
        logic [8:0] lc;
        logic       mk;
        logic [8:0] probe;
        logic       probe_bit;
        int         cnt;
        string      name;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic v, input logic e, input logic [7:0] b,
                                 input logic kv, input logic se, input logic [8:0] lc,
                                 input logic mk, input logic [8:0] probe, input logic pbit,
                                 input int cnt, input string name);
        vec_t r;
        r.v = v; r.e = e; r.b = b; r.kv = kv; r.se = se; r.lc = lc; r.mk = mk;
        r.probe = probe; r.probe_bit = pbit; r.cnt = cnt; r.name = name;
        return r;
    endfunction

    task automatic apply(input vec_t t);
        vec_t g;
        @(negedge clk);
        byte_valid = t.v;
        byte_err   = t.e;
        byte_in    = t.b;
        exp_q.push_back(t);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_err   = 1'b0;
        g = exp_q.pop_front();
        chk($sformatf("%s key_valid", g.name), int'(key_valid), int'(g.kv));
        chk($sformatf("%s seq_err", g.name), int'(seq_err), int'(g.se));
        chk($sformatf("%s last_change", g.name), int'(last_change), int'(g.lc));
        chk($sformatf("%s key_is_make", g.name), int'(key_is_make), int'(g.mk));
        chk($sformatf("%s key_down[%0h]", g.name, g.probe), int'(key_down[g.probe]),
            int'(g.probe_bit));
        chk($sformatf("%s held_count", g.name), $countones(key_down), g.cnt);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pause_seq [8];
        int         pulses;
        int         bad;

        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        // v, e, byte, key_valid, seq_err, last_change, key_is_make, probe, probe bit, count
        vecs.push_back(mkv(1, 0, 8'h1C, 1, 0, 9'h01C, 1, 9'h01C, 1, 1, "make_1c"));
        vecs.push_back(mkv(1, 0, 8'hF0, 0, 0, 9'h01C, 1, 9'h01C, 1, 1, "brk_prefix"));
        vecs.push_back(mkv(1, 0, 8'h1C, 1, 0, 9'h01C, 0, 9'h01C, 0, 0, "break_1c"));
        vecs.push_back(mkv(1, 0, 8'hE0, 0, 0, 9'h01C, 0, 9'h175, 0, 0, "ext_prefix"));
        vecs.push_back(mkv(1, 0, 8'h75, 1, 0, 9'h175, 1, 9'h175, 1, 1, "make_e075"));
        vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 9'h175, 1, 9'h075, 0, 1, "no_075"));
        vecs.push_back(mkv(1, 0, 8'hE0, 0, 0, 9'h175, 1, 9'h175, 1, 1, "ext_prefix2"));
        vecs.push_back(mkv(1, 0, 8'hF0, 0, 0, 9'h175, 1, 9'h175, 1, 1, "ext_brk_prefix"));
        vecs.push_back(mkv(1, 0, 8'h75, 1, 0, 9'h175, 0, 9'h175, 0, 0, "break_e075"));
        vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 9'h175, 0, 9'h075, 0, 0, "no_075b"));
        vecs.push_back(mkv(1, 0, 8'h12, 1, 0, 9'h012, 1, 9'h012, 1, 1, "make_12"));
        vecs.push_back(mkv(1, 0, 8'h21, 1, 0, 9'h021, 1, 9'h012, 1, 2, "make_21"));
        vecs.push_back(mkv(1, 0, 8'hF0, 0, 0, 9'h021, 1, 9'h021, 1, 2, "brk_prefix2"));
        vecs.push_back(mkv(1, 0, 8'h12, 1, 0, 9'h012, 0, 9'h012, 0, 1, "break_12"));
        vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 9'h012, 0, 9'h021, 1, 1, "hold_21"));
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mkv(1, 0, pause_seq[i], 0, 0, 9'h012, 0, 9'h014, 0, 1,
                               $sformatf("pause_%0d", i)));
        end
        vecs.push_back(mkv(1, 0, 8'h23, 1, 0, 9'h023, 1, 9'h023, 1, 2, "make_23"));
        vecs.push_back(mkv(1, 0, 8'hE0, 0, 0, 9'h023, 1, 9'h175, 0, 2, "ext_prefix3"));
        vecs.push_back(mkv(0, 1, 8'h00, 0, 1, 9'h023, 1, 9'h175, 0, 2, "ext_rx_err"));
        vecs.push_back(mkv(1, 0, 8'h75, 1, 0, 9'h075, 1, 9'h075, 1, 3, "make_75_after_err"));
        vecs.push_back(mkv(0, 0, 8'h00, 0, 0, 9'h075, 1, 9'h175, 0, 3, "no_175"));
        vecs.push_back(mkv(1, 0, 8'hF0, 0, 0, 9'h075, 1, 9'h075, 1, 3, "brk_prefix3"));
        vecs.push_back(mkv(1, 0, 8'hE0, 0, 1, 9'h075, 1, 9'h075, 1, 3, "brk_bad_prefix"));
        vecs.push_back(mkv(1, 0, 8'h1C, 1, 0, 9'h01C, 1, 9'h01C, 1, 4, "make_1c_again"));
        vecs.push_back(mkv(0, 1, 8'h00, 0, 1, 9'h01C, 1, 9'h01C, 1, 4, "idle_rx_err"));
        vecs.push_back(mkv(1, 0, 8'h1C, !RepFilt, 0, 9'h01C, 1, 9'h01C, 1, 4, "repeat_1c_a"));
        vecs.push_back(mkv(1, 0, 8'h1C, !RepFilt, 0, 9'h01C, 1, 9'h01C, 1, 4, "repeat_1c_b"));
        vecs.push_back(mkv(1, 0, 8'hAA, 0, 0, 9'h01C, 1, 9'h0AA, 0, 4, "ignore_aa"));
        vecs.push_back(mkv(1, 0, 8'hFA, 0, 0, 9'h01C, 1, 9'h0FA, 0, 4, "ignore_fa"));
        vecs.push_back(mkv(1, 0, 8'h00, 0, 0, 9'h01C, 1, 9'h01C, 0, 0, "overrun_00"));
        vecs.push_back(mkv(1, 0, 8'hF0, 0, 0, 9'h01C, 1, 9'h01C, 0, 0, "brk_prefix4"));
        vecs.push_back(mkv(1, 0, 8'h33, 1, 0, 9'h033, 0, 9'h033, 0, 0, "break_unheld"));
        vecs.push_back(mkv(1, 0, 8'hE0, 0, 0, 9'h033, 0, 9'h1E1, 0, 0, "ext_prefix4"));
        vecs.push_back(mkv(1, 0, 8'hF0, 0, 0, 9'h033, 0, 9'h1E1, 0, 0, "ext_brk_prefix2"));
        vecs.push_back(mkv(1, 0, 8'hE1, 0, 1, 9'h033, 0, 9'h1E1, 0, 0, "extbrk_bad_prefix"));
        vecs.push_back(mkv(1, 0, 8'hE0, 0, 0, 9'h033, 0, 9'h112, 0, 0, "ext_prefix5"));
        vecs.push_back(mkv(1, 0, 8'hE0, 0, 0, 9'h033, 0, 9'h112, 0, 0, "ext_repeat_e0"));
        vecs.push_back(mkv(1, 0, 8'h12, 1, 0, 9'h112, 1, 9'h112, 1, 1, "make_e012"));
        vecs.push_back(mkv(1, 0, 8'h21, 1, 0, 9'h021, 1, 9'h021, 1, 2, "make_21b"));
        vecs.push_back(mkv(1, 0, 8'hFF, 0, 0, 9'h021, 1, 9'h021, 0, 0, "overrun_ff"));

        byte_in    = 8'h00;
        byte_valid = 1'b0;
        byte_err   = 1'b0;
        rst        = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("reset key_down", $countones(key_down), 0);
        chk("reset last_change", int'(last_change), 0);
        chk("reset key_is_make", int'(key_is_make), 0);
        chk("reset key_valid", int'(key_valid), 0);
        chk("reset seq_err", int'(seq_err), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // Stalled break prefix is abandoned exactly once, then decoding restarts from idle.
        send_byte(8'hF0);
        pulses = 0;
        for (int i = 0; i < int'(Tmo) + 10; i++) begin
            @(posedge clk);
            #1;
            if (seq_err) pulses++;
        end
        chk("timeout seq_err pulses", pulses, 1);
        send_byte(8'h24);
        chk("after_timeout key_valid", int'(key_valid), 1);
        chk("after_timeout last_change", int'(last_change), 'h024);
        chk("after_timeout key_is_make", int'(key_is_make), 1);
        chk("after_timeout key_down[024]", int'(key_down[9'h024]), 1);

        // A byte arriving on the last idle cycle before expiry wins over the timeout.
        send_byte(8'hF0);
        bad = 0;
        for (int i = 0; i < int'(Tmo) - 1; i++) begin
            @(posedge clk);
            #1;
            if (seq_err) bad++;
        end
        send_byte(8'h24);
        if (seq_err) bad++;
        chk("coincident key_valid", int'(key_valid), 1);
        chk("coincident key_is_make", int'(key_is_make), 0);
        chk("coincident key_down[024]", int'(key_down[9'h024]), 0);
        for (int i = 0; i < int'(Tmo) + 5; i++) begin
            @(posedge clk);
            #1;
            if (seq_err) bad++;
        end
        chk("coincident seq_err pulses", bad, 0);

        // Reset mid-sequence drops the E0 prefix and the held key.
        send_byte(8'h1C);
        send_byte(8'hE0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset key_down", $countones(key_down), 0);
        chk("midreset last_change", int'(last_change), 0);
        chk("midreset key_is_make", int'(key_is_make), 0);
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h75);
        chk("post_reset key_valid", int'(key_valid), 1);
        chk("post_reset last_change", int'(last_change), 'h075);
        chk("post_reset key_down[075]", int'(key_down[9'h075]), 1);
        chk("post_reset key_down[175]", int'(key_down[9'h175]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_state_tracker.md
# key_state_tracker

Converts the PS/2 scan-code byte stream from the keyboard byte receiver into a 512-bit pressed-key vector plus a change strobe. It is the producer side of the key vector consumed by the note generator and other keyboard-driven blocks. Index format is {extended, code}: bit 8 is set for E0-prefixed keys, so Left Shift is 0x012 and Right Ctrl is 0x114. Set 2 make/break prefixes, the Pause sequence, overrun codes, receiver errors and stalled prefixes are all handled here.

## Interface
- TIMEOUT_CYC, 2_000_000, idle clock cycles after a prefix byte before the partial sequence is abandoned (20 ms at 100 MHz)
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- byte_in  in  8  received scan-code byte
- byte_valid  in  1  one-cycle strobe qualifying byte_in
- byte_err  in  1  one-cycle strobe from the receiver on a parity or framing error; never coincident with byte_valid
- key_down  out  512  bit i is 1 while key index i is held
- last_change  out  9  index of the most recent make or break
- key_is_make  out  1  1 if the last change was a make, 0 if it was a break
- key_valid  out  1  one-cycle pulse when key_down or last_change has been updated
- seq_err  out  1  one-cycle pulse when a partial sequence is discarded

## Operation
- Reset values (asynchronous, immediate): key_down=0, last_change=0, key_is_make=0, key_valid=0, seq_err=0, state IDLE, skip counter 0, timeout counter 0.
- States are IDLE, EXT (E0 received), BRK (F0 received), EXT_BRK (E0 F0 received) and SKIP (Pause sequence in progress).
- Transitions on byte_valid:
  - IDLE:
    - E0 goes to EXT.
    - F0 goes to BRK.
    - E1 goes to SKIP with the counter set to 7.
    - 00 or FF (overrun) clears all of key_down, with no key_valid pulse.
    - AA, FA, EE, FC and FE are ignored.
    - Any other byte b is a make of {0,b}.
  - EXT:
    - F0 goes to EXT_BRK.
    - E0 stays in EXT.
    - Any other byte b is a make of {1,b}, then IDLE.
  - BRK: E0, E1 or F0 pulses seq_err and returns to IDLE. Any other byte b is a break of {0,b}, then IDLE.
  - EXT_BRK: a prefix byte pulses seq_err and returns to IDLE. Any other byte b is a break of {1,b}, then IDLE.
  - SKIP: each byte is discarded and decrements the counter. When the counter reaches 0, return to IDLE. No key bits change.
- A make sets key_down[idx], loads last_change=idx and key_is_make=1, and pulses key_valid.
- A break clears key_down[idx], loads last_change=idx and key_is_make=0, and pulses key_valid.
- A break of a key that is not held still updates last_change and pulses key_valid.
- byte_err in any state other than IDLE pulses seq_err and returns to IDLE. byte_err in IDLE pulses seq_err only.
- Timeout counter:
  - Runs only in EXT, BRK, EXT_BRK and SKIP.
  - Clears on every byte_valid.
  - Reaching TIMEOUT_CYC pulses seq_err and forces IDLE.
- The counter is sized by $clog2(TIMEOUT_CYC+1).

## Timing
- All outputs are registered. byte_valid in cycle N produces key_down, last_change and key_valid in cycle N+1.
- key_valid and seq_err are high for exactly one cycle. Back-to-back byte_valid strobes produce back-to-back pulses.
- Timeout and byte_valid in the same cycle: the byte wins and the timeout is cancelled.
- A one-cycle gap between bytes is not required. A byte is accepted every cycle.
- Asserting rst mid-sequence drops the prefix. The first byte after rst deasserts is decoded from IDLE.

## Configuration
- KEY_REPEAT_FILTER_EN defined: a make of an index already set in key_down updates nothing and does not pulse key_valid, so typematic repeat is suppressed.
- KEY_REPEAT_FILTER_EN undefined: every make pulses key_valid and reloads last_change, including repeats.

## Test plan
- Bytes 1C, then F0 1C:
  - After 1C: key_down[0x01C]=1, last_change=0x01C, key_is_make=1, and one key_valid pulse in cycle N+1.
  - After F0 1C: bit 0x01C clears, key_is_make=0, and one more key_valid pulse.
- Bytes E0 75, then E0 F0 75: bit 0x175 sets and then clears. Bit 0x075 stays 0 throughout. last_change=0x175.
- Bytes 12, 21, then F0 12: after 12 21, bits 0x012 and 0x021 are both 1. After F0 12, only 0x021 remains set.
- Bytes E1 14 77 E1 F0 14 F0 77, then 23:
  - The Pause sequence produces no key_valid and leaves key_down unchanged.
  - The following 23 sets bit 0x023.
- Prefix abandonment:
  - F0 followed by TIMEOUT_CYC idle cycles pulses seq_err once. A subsequent 24 sets bit 0x024.
  - E0 then byte_err pulses seq_err. A subsequent 75 sets 0x075, not 0x175.
  - With keys held, byte 00 clears all of key_down.
- Bytes 1C 1C 1C: with KEY_REPEAT_FILTER_EN defined, exactly one key_valid pulse. Without it, three pulses.
